// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
//
// Serialises one byte per frame as start bit (0), 8 data bits LSB first,
// an optional parity bit and 1 or 2 stop bits (1). The internal baud divider
// restarts when a frame is accepted, so every bit is exactly CLKS_PER_BIT
// clocks long. All outputs are registered.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   PARITY_EN     1 = insert a parity bit after the data bits
//   PARITY_ODD    parity sense when enabled: 0 = even, 1 = odd
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   tx_start  in   request to send data_in (accepted only while not busy)
//   data_in   in   byte to send, captured on an accepted request
//   txd       out  serial line, idles high
//   busy      out  high while a frame is in progress
//   tx_done   out  one-cycle pulse after the last stop bit completes
//   bit_tick  out  one-cycle pulse on the final clock of each bit period
module uart_tx #(
  parameter int CLKS_PER_BIT = 2605,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       txd,
  output logic       busy,
  output logic       tx_done,
  output logic       bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick_q, tick_d;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic: baud divider, frame sequencing and next output values.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tick_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d = data_in;
          // Parity is taken from the byte now, since the shifter consumes it.
          par_d   = (^data_in) ^ (PARITY_ODD != 0);
          state_d = START;
          baud_d  = '0;
          bit_d   = 3'd0;
          stop_d  = 1'b0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          txd_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      START, DATA, PARITY, STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          case (state_q)
            START: begin
              state_d = DATA;
              bit_d   = 3'd0;
              txd_d   = shift_q[0];
            end
            DATA: begin
              if (bit_q == 3'd7) begin
                if (PARITY_EN != 0) begin
                  state_d = PARITY;
                  txd_d   = par_q;
                end else begin
                  state_d = STOP;
                  stop_d  = 1'b0;
                  txd_d   = 1'b1;
                end
              end else begin
                shift_d = {1'b0, shift_q[7:1]};
                txd_d   = shift_q[1];
                bit_d   = bit_q + 3'd1;
              end
            end
            PARITY: begin
              state_d = STOP;
              stop_d  = 1'b0;
              txd_d   = 1'b1;
            end
            STOP: begin
              if ((STOP_BITS == 2) && !stop_q) begin
                stop_d = 1'b1;
                txd_d  = 1'b1;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                txd_d   = 1'b1;
              end
            end
            default: begin
              state_d = IDLE;
              busy_d  = 1'b0;
              txd_d   = 1'b1;
            end
          endcase
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase

    // Registered tick lands in the cycle whose count is the last of the bit.
    tick_d = busy_d && (baud_d == BAUD_MAX);
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign bit_tick = tick_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Five instances cover 8N1, 8E1, 8O1, 8N2 at 16 clocks/bit and 8N1 at the
// default divider. Expected bytes go into a scoreboard queue when a frame is
// started and are compared with the byte decoded from txd.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       start_s [5];
  logic [7:0] data_s  [5];
  logic       txd_s   [5];
  logic       busy_s  [5];
  logic       done_s  [5];
  logic       tick_s  [5];

  int cpb     [5] = '{16, 16, 16, 16, 2605};
  int par_en  [5] = '{0, 1, 1, 0, 0};
  int par_odd [5] = '{0, 0, 1, 0, 0};
  int stop_n  [5] = '{1, 1, 1, 2, 1};

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q [$];

  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .reset(reset), .tx_start(start_s[0]), .data_in(data_s[0]),
    .txd(txd_s[0]), .busy(busy_s[0]), .tx_done(done_s[0]), .bit_tick(tick_s[0]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
    .clk(clk), .reset(reset), .tx_start(start_s[1]), .data_in(data_s[1]),
    .txd(txd_s[1]), .busy(busy_s[1]), .tx_done(done_s[1]), .bit_tick(tick_s[1]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
    .clk(clk), .reset(reset), .tx_start(start_s[2]), .data_in(data_s[2]),
    .txd(txd_s[2]), .busy(busy_s[2]), .tx_done(done_s[2]), .bit_tick(tick_s[2]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .reset(reset), .tx_start(start_s[3]), .data_in(data_s[3]),
    .txd(txd_s[3]), .busy(busy_s[3]), .tx_done(done_s[3]), .bit_tick(tick_s[3]));
  uart_tx u_def (
    .clk(clk), .reset(reset), .tx_start(start_s[4]), .data_in(data_s[4]),
    .txd(txd_s[4]), .busy(busy_s[4]), .tx_done(done_s[4]), .bit_tick(tick_s[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level expected during bit b of a frame carrying d on instance k.
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if ((b == 9) && (par_en[k] != 0)) return (^d) ^ (par_odd[k] != 0);
    return 1'b1;
  endfunction

  // Called at a negedge: request a frame; returns at the negedge after the
  // accepting edge (frame cycle 0). With hold=1 tx_start stays asserted.
  task automatic start_frame(input int k, input logic [7:0] d, input bit hold);
    start_s[k] = 1'b1;
    data_s[k]  = d;
    @(negedge clk);
    if (!hold) start_s[k] = 1'b0;
  endtask

  // Entered at frame cycle 0; returns at the tx_done cycle.
  task automatic run_frame(input int k, input logic [7:0] d);
    int n = cpb[k];
    int f = 9 + par_en[k] + stop_n[k];
    int bad = 0;
    int busy_n = 0;
    int ticks = 0;
    int dones = 0;
    logic [7:0] dec = 8'h00;
    logic par_seen = 1'b0;
    for (int c = 0; c <= f * n; c++) begin
      int b;
      b = c / n;
      ticks += int'(tick_s[k]);
      if (c < f * n) begin
        if (txd_s[k] !== exp_bit(k, d, b)) bad++;
        if (busy_s[k]) busy_n++;
        if (done_s[k]) dones++;
        if ((c % n) == (n / 2)) begin
          if ((b >= 1) && (b <= 8)) dec[b-1] = txd_s[k];
          if ((b == 9) && (par_en[k] != 0)) par_seen = txd_s[k];
        end
        @(negedge clk);
      end else begin
        check($sformatf("done_pulse[%0d]", k), {31'd0, done_s[k]}, 32'd1);
        check($sformatf("busy_end[%0d]", k), {31'd0, busy_s[k]}, 32'd0);
        check($sformatf("txd_end[%0d]", k), {31'd0, txd_s[k]}, 32'd1);
      end
    end
    check($sformatf("txd_bits[%0d]", k), bad, 0);
    check($sformatf("busy_len[%0d]", k), busy_n, f * n);
    check($sformatf("tick_cnt[%0d]", k), ticks, f);
    check($sformatf("early_done[%0d]", k), dones, 0);
    if (par_en[k] != 0)
      check($sformatf("parity[%0d]", k), {31'd0, par_seen}, {31'd0, (^d) ^ (par_odd[k] != 0)});
    if (sb_q.size() == 0) begin
      check($sformatf("sb_empty[%0d]", k), 32'd0, 32'd1);
    end else begin
      check($sformatf("sb_data[%0d]", k), {24'd0, dec}, {24'd0, sb_q.pop_front()});
    end
  endtask

  initial begin
    int dn;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_s[i] = 1'b0;
      data_s[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_txd[%0d]", i), {31'd0, txd_s[i]}, 32'd1);
      check($sformatf("rst_busy[%0d]", i), {31'd0, busy_s[i]}, 32'd0);
      check($sformatf("rst_done[%0d]", i), {31'd0, done_s[i]}, 32'd0);
      check($sformatf("rst_tick[%0d]", i), {31'd0, tick_s[i]}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Basic 8N1
    sb_q.push_back(8'hA5);
    start_frame(0, 8'hA5, 1'b0);
    run_frame(0, 8'hA5);
    @(negedge clk);

    // Back-to-back with tx_start held and data_in changed mid-frame
    sb_q.push_back(8'h3C);
    start_frame(0, 8'h3C, 1'b1);
    data_s[0] = 8'hC3;
    sb_q.push_back(8'hC3);
    run_frame(0, 8'h3C);
    @(negedge clk);
    start_s[0] = 1'b0;
    run_frame(0, 8'hC3);
    @(negedge clk);

    // Reset mid-frame
    start_frame(0, 8'hFF, 1'b0);
    repeat (70) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_txd", {31'd0, txd_s[0]}, 32'd1);
    check("midrst_busy", {31'd0, busy_s[0]}, 32'd0);
    reset = 1'b0;
    dn = int'(done_s[0]);
    repeat (20) begin
      @(negedge clk);
      dn += int'(done_s[0]) + int'(busy_s[0]);
    end
    check("midrst_quiet", dn, 0);
    sb_q.push_back(8'h55);
    start_frame(0, 8'h55, 1'b0);
    run_frame(0, 8'h55);
    @(negedge clk);

    // Reset and tx_start in the same cycle: request dropped
    reset = 1'b1;
    start_s[0] = 1'b1;
    data_s[0] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    start_s[0] = 1'b0;
    check("rst_start_busy", {31'd0, busy_s[0]}, 32'd0);
    @(negedge clk);
    check("rst_start_idle", {31'd0, busy_s[0]}, 32'd0);
    check("rst_start_txd", {31'd0, txd_s[0]}, 32'd1);

    // Even parity, odd parity, two stop bits
    sb_q.push_back(8'hA5);
    start_frame(1, 8'hA5, 1'b0);
    run_frame(1, 8'hA5);
    sb_q.push_back(8'hA5);
    start_frame(2, 8'hA5, 1'b0);
    run_frame(2, 8'hA5);
    sb_q.push_back(8'h00);
    start_frame(3, 8'h00, 1'b0);
    run_frame(3, 8'h00);
    @(negedge clk);

    // Default divider
    sb_q.push_back(8'h81);
    start_frame(4, 8'h81, 1'b0);
    run_frame(4, 8'h81);

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
